// File: rtl/regfile_wb_if.sv
// Bundle of write-back, read-port and issue signals shared between the
// decode/pipeline side (master) and the register file (slave).
interface regfile_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs1_use;
    logic              rs2_use;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    logic              iss_valid;
    logic              iss_rd_we;
    logic [ADDR_W-1:0] iss_rd_addr;
    logic              iss_ready;

    logic              wb_underflow;

    // Decode stage plus pipeline write-back: drives requests, observes results.
    modport master (
        output rd_we, rd_addr, rd_data,
        output rs1_addr, rs2_addr, rs1_use, rs2_use,
        output iss_valid, iss_rd_we, iss_rd_addr,
        input  rs1_data, rs2_data, iss_ready, wb_underflow
    );

    // Register file: consumes requests, produces read data and issue status.
    modport slave (
        input  rd_we, rd_addr, rd_data,
        input  rs1_addr, rs2_addr, rs1_use, rs2_use,
        input  iss_valid, iss_rd_we, iss_rd_addr,
        output rs1_data, rs2_data, iss_ready, wb_underflow
    );
endinterface

// File: rtl/regfile_wb.sv
// Architectural register file with write-through read bypass and a
// per-register saturating pending-writer scoreboard used to stall issue on
// RAW hazards. x0 is hardwired to zero and never tracked.
// The interface instance must use the same DATA_W/ADDR_W as this module.
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  bus
);

    localparam int                NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] X0      = '0;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  pend_q [NREG];
    logic [CNT_W-1:0]  pend_d [NREG];
    logic              underflow_q;
    logic              underflow_d;

    logic wb_hit;
    logic busy1;
    logic busy2;
    logic sat_stall;
    logic stall;
    logic iss_hit;

    // A register is busy while writers are outstanding, except when the only
    // remaining writer lands this cycle: the bypass then supplies its data.
    function automatic logic busyOf(
        input logic [ADDR_W-1:0] r,
        input logic [CNT_W-1:0]  pend_r,
        input logic              wb,
        input logic [ADDR_W-1:0] wb_addr
    );
        return (r != X0) && (pend_r != '0) &&
               !(wb && (wb_addr == r) && (pend_r == CNT_ONE));
    endfunction

    // Read port value: landing write-back wins, x0 always reads zero.
    function automatic logic [DATA_W-1:0] readPort(
        input logic [ADDR_W-1:0] a,
        input logic              wb,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data,
        input logic [DATA_W-1:0] stored
    );
        if (wb && (wb_addr == a)) begin
            return wb_data;
        end
        if (a == X0) begin
            return '0;
        end
        return stored;
    endfunction

    // Combinational read ports with same-cycle write-through bypass.
    always_comb begin
        wb_hit       = bus.rd_we && (bus.rd_addr != X0);
        bus.rs1_data = readPort(bus.rs1_addr, wb_hit, bus.rd_addr, bus.rd_data,
                                regs_q[bus.rs1_addr]);
        bus.rs2_data = readPort(bus.rs2_addr, wb_hit, bus.rd_addr, bus.rd_data,
                                regs_q[bus.rs2_addr]);
    end

    // Hazard detection: RAW on either source plus the counter saturation
    // guard, which is lifted when a write-back to the same register frees a
    // slot on this very edge.
    always_comb begin
        busy1     = busyOf(bus.rs1_addr, pend_q[bus.rs1_addr], wb_hit, bus.rd_addr);
        busy2     = busyOf(bus.rs2_addr, pend_q[bus.rs2_addr], wb_hit, bus.rd_addr);
        sat_stall = bus.iss_rd_we && (bus.iss_rd_addr != X0) &&
                    (pend_q[bus.iss_rd_addr] == CNT_MAX) &&
                    !(wb_hit && (bus.rd_addr == bus.iss_rd_addr));
        stall     = bus.iss_valid &&
                    ((bus.rs1_use && busy1) || (bus.rs2_use && busy2) || sat_stall);
        bus.iss_ready = !stall;
        iss_hit   = bus.iss_valid && !stall && bus.iss_rd_we &&
                    (bus.iss_rd_addr != X0);
        bus.wb_underflow = underflow_q;
    end

    // Next-state for data and scoreboard. A simultaneous issue and
    // write-back cancel out, except that a write-back arriving on an empty
    // counter together with an issue leaves one writer outstanding and is not
    // treated as an underflow.
    always_comb begin
        regs_d      = regs_q;
        pend_d      = pend_q;
        underflow_d = underflow_q;
        if (wb_hit) begin
            regs_d[bus.rd_addr] = bus.rd_data;
        end
        for (int i = 1; i < NREG; i++) begin
            if (iss_hit && (bus.iss_rd_addr == ADDR_W'(i)) &&
                wb_hit && (bus.rd_addr == ADDR_W'(i))) begin
                if (pend_q[i] == '0) begin
                    pend_d[i] = CNT_ONE;
                end
            end else if (iss_hit && (bus.iss_rd_addr == ADDR_W'(i))) begin
                pend_d[i] = pend_q[i] + CNT_ONE;
            end else if (wb_hit && (bus.rd_addr == ADDR_W'(i))) begin
                if (pend_q[i] == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] - CNT_ONE;
                end
            end
        end
    end

    // State registers; reset clears data, scoreboard and the sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q      <= '{default: '0};
            pend_q      <= '{default: '0};
            underflow_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            pend_q      <= pend_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural integer register file: the write-back endpoint of the rd channel (rd_we / rd_addr / rd_data) driven by the EX/MEM/WB pipeline registers.
- Provides two combinational read ports to ID with same-cycle write-through bypass.
- Tracks in-flight writers per register with a saturating pending-count scoreboard, so ID stalls on true RAW hazards.
- Sits between the decode stage and the end of the execute/memory pipeline.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width; 2**ADDR_W registers.
- CNT_W, 2, width of each per-register pending counter; max in-flight writers per register = 2**CNT_W-1.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- rd_we  input  1  write-back enable.
- rd_addr  input  ADDR_W  write-back register index.
- rd_data  input  DATA_W  write-back data.
- rs1_addr  input  ADDR_W  read port 1 index.
- rs2_addr  input  ADDR_W  read port 2 index.
- rs1_use  input  1  instruction in ID actually reads rs1.
- rs2_use  input  1  instruction in ID actually reads rs2.
- rs1_data  output  DATA_W  read data 1 (combinational).
- rs2_data  output  DATA_W  read data 2 (combinational).
- iss_valid  input  1  ID presents an instruction for issue.
- iss_rd_we  input  1  issuing instruction will write rd.
- iss_rd_addr  input  ADDR_W  issuing instruction's rd.
- iss_ready  output  1  issue accepted this cycle when iss_valid=1.
- wb_underflow  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, async): all registers = 0, all pending counters = 0, wb_underflow = 0. rs*_data therefore read 0 and iss_ready = 1 while in reset.
- x0: reads always return 0. Writes to x0 are ignored and never decrement. Issue to x0 never increments. x0 is never busy.
- Write: on posedge, if rd_we=1 and rd_addr!=0, then regs[rd_addr] <= rd_data. Pending[rd_addr] decrements, except as noted under "Same-edge issue and write-back".
- Decrement underflow: if pending[rd_addr] is already 0, the counter stays 0 and wb_underflow sets. It clears only on reset.
- Read bypass: if rd_we=1, rd_addr!=0 and rd_addr==rsN_addr, then rsN_data = rd_data in the same cycle. Otherwise rsN_data = regs[rsN_addr].
- busy(r) = (r!=0) and (pending[r]!=0). The one exception: if rd_we=1, rd_addr==r and pending[r]==1 this cycle, then busy(r) = 0, because the last writer is landing and the bypass supplies the data.
- Stall terms, each evaluated with iss_valid=1:
  - rs1_use and busy(rs1_addr);
  - rs2_use and busy(rs2_addr);
  - iss_rd_we, iss_rd_addr!=0, and pending[iss_rd_addr]==MAX, with no write-back hitting iss_rd_addr this cycle (saturation guard).
- iss_ready = not stall. When iss_valid=0, iss_ready = 1.
- Accept = iss_valid and iss_ready. On accept with iss_rd_we=1 and iss_rd_addr!=0, pending[iss_rd_addr] increments on the posedge.
- Same-edge issue and write-back to the same register: the counter is unchanged (net 0). Register data still updates.
- Write-back to a register with pending 0 while an issue to it is accepted on the same edge: the counter becomes 1 and wb_underflow does not set.
- Independent registers update independently on the same edge.
- Write-back is never back-pressured; rd_we is always consumed.
- Reset asserted mid-operation: all counters clear immediately. Write-backs for instructions issued before reset are the pipeline's responsibility to suppress; any that arrive raise wb_underflow.
- No combinational path from rd_* to iss_ready except through busy() and the saturation guard. There is no path from iss_* to rs*_data.

Test Plan:
- Reset, then read x1..x31 -> all 0. Write x0=0xFFFFFFFF -> read x0 = 0; pending[0] stays 0; wb_underflow = 0.
- Issue rd=x5 (pending 1). Next cycle ID uses rs1=x5 -> iss_ready=0. Write-back x5=0x1234 in that cycle -> rs1_data=0x1234 and iss_ready=1 the same cycle. Pending becomes 0.
- Issue rd=x7 three times (CNT_W=2, pending 3). Fourth issue to x7 -> iss_ready=0. Same cycle with write-back x7 -> accepted, pending stays 3.
- Pending[x9]=2, write-back x9=0xA, rs2=x9 with rs2_use=1 -> iss_ready=0 (newer writer outstanding). Second write-back 0xB -> rs2_data=0xB and iss_ready=1.
- Write-back x3 with pending[x3]=0 and no issue -> regs[x3] updated, wb_underflow=1 and stays 1. Assert rst=0 asynchronously mid-cycle -> wb_underflow and all counters 0 before the next edge.
- Simultaneous issue rd=x4 and write-back x4 with pending 1 -> pending stays 1; regs[x4]=new data. rs1=x4 with rs1_use=1 -> stall next cycle.
